// File: rtl/cpu_clock_sequencer_if.sv
// cpu_clock_sequencer_if: bundles the board-side controls and the CPU-side clock/reset/status of the sequencer.
// Latency: none, wires only.
// Backpressure: none; level signals with no handshake.
//
// master : the sequencer (consumes the raw controls, drives the CPU clock/reset/status)
// slave  : the surrounding FPGA top / board pins / CPU
interface cpu_clock_sequencer_if #(
    parameter int CntWidth = 16
);
    // Raw board controls and CPU halt flag, all asynchronous to Clk.
    logic                Run_Sw;
    logic                Step_Btn;
    logic                Restart;
    logic                Halt;

    // CPU clock, CPU reset (active low) and status.
    logic                Cpu_Clk;
    logic                Cpu_Reset;
    logic [2:0]          State;
    logic [CntWidth-1:0] Cycle_Count;
    logic                Heartbeat;

    modport master (
        input  Run_Sw,
        input  Step_Btn,
        input  Restart,
        input  Halt,
        output Cpu_Clk,
        output Cpu_Reset,
        output State,
        output Cycle_Count,
        output Heartbeat
    );

    modport slave (
        output Run_Sw,
        output Step_Btn,
        output Restart,
        output Halt,
        input  Cpu_Clk,
        input  Cpu_Reset,
        input  State,
        input  Cycle_Count,
        input  Heartbeat
    );
endinterface

// File: rtl/cpu_clock_sequencer.sv
// cpu_clock_sequencer: derives the gated CPU clock and CPU reset from the board clock (free-run, single-step, halt).
// Latency: controls take 2 Clk to synchronise (+DbMax+1 Clk debounce for step/restart); CPU clock edges land on the Clk after tc.
// Backpressure: none; requests that arrive mid-phase wait for the next phase boundary, extra step presses are dropped.
//
// Ports:
//   Clk    - board clock
//   Reset  - asynchronous active-low reset of the whole sequencer
//   bus    - master side of cpu_clock_sequencer_if:
//            in : Run_Sw, Step_Btn, Restart, Halt (raw, asynchronous)
//            out: Cpu_Clk, Cpu_Reset (active low), State, Cycle_Count, Heartbeat (all registered)
module cpu_clock_sequencer #(
    parameter int DivWidth = 23,
    parameter int DivMax   = 7_999_999,
    parameter int DbWidth  = 16,
    parameter int DbMax    = 47_999,
    parameter int RstHold  = 4,
    parameter int CntWidth = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    cpu_clock_sequencer_if.master bus
);

    // Wide enough to hold the value RstHold (and at least one bit).
    localparam int RhWidth = $clog2(RstHold + 2);

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RUN      = 3'd2,
        ST_STEP_HI  = 3'd3,
        ST_STEP_LO  = 3'd4,
        ST_HALTED   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. Bit order: 0 Run_Sw, 1 Step_Btn, 2 Restart, 3 Halt.
    // ------------------------------------------------------------------
    logic [3:0] raw_in;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    assign raw_in = {bus.Halt, bus.Restart, bus.Step_Btn, bus.Run_Sw};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    logic run_s;
    logic halt_s;

    assign run_s  = sync2_q[0];
    assign halt_s = sync2_q[3];

    // ------------------------------------------------------------------
    // Debouncers for Step_Btn (index 0) and Restart (index 1).
    // The counter runs only while the synchronised sample disagrees with the
    // accepted level; any agreeing sample restarts the qualification window.
    // ------------------------------------------------------------------
    logic [1:0]              db_in;
    logic [1:0][DbWidth-1:0] db_cnt_q;
    logic [1:0][DbWidth-1:0] db_cnt_d;
    logic [1:0]              db_lvl_q;
    logic [1:0]              db_lvl_d;
    logic [1:0]              db_pulse_q;
    logic [1:0]              db_pulse_d;

    assign db_in = {sync2_q[2], sync2_q[1]};

    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_lvl_d   = db_lvl_q;
        db_pulse_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (db_in[i] == db_lvl_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbWidth'(DbMax)) begin
                db_cnt_d[i]   = '0;
                db_lvl_d[i]   = db_in[i];
                db_pulse_d[i] = db_in[i];   // rising edge of the accepted level only
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DbWidth'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            db_cnt_q   <= '0;
            db_lvl_q   <= '0;
            db_pulse_q <= '0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_lvl_q   <= db_lvl_d;
            db_pulse_q <= db_pulse_d;
        end
    end

    logic step_pulse;
    logic restart_pulse;

    assign step_pulse    = db_pulse_q[0];
    assign restart_pulse = db_pulse_q[1];

    // ------------------------------------------------------------------
    // Phase divider and heartbeat. tc marks the last Clk of every phase, so
    // every CPU clock edge produced from it is exactly DivMax+1 Clk apart.
    // ------------------------------------------------------------------
    logic [DivWidth-1:0] div_q;
    logic [DivWidth-1:0] div_d;
    logic                tc;
    logic                hb_q;

    assign tc    = (div_q == DivWidth'(DivMax));
    assign div_d = tc ? '0 : div_q + DivWidth'(1);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_q <= '0;
            hb_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            hb_q  <= hb_q ^ tc;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM.
    // ------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic                cpu_clk_q;
    logic                cpu_clk_d;
    logic                cpu_rst_q;
    logic                cpu_rst_d;
    logic [RhWidth-1:0]  rises_q;
    logic [RhWidth-1:0]  rises_d;
    logic                step_pend_q;
    logic                step_pend_d;
    logic                stop_req_q;
    logic                stop_req_d;
    logic                halt_req_q;
    logic                halt_req_d;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;
    logic                cnt_inc;
    logic                stop_now;
    logic                halt_now;

    always_comb begin
        state_d     = state_q;
        cpu_clk_d   = cpu_clk_q;
        cpu_rst_d   = cpu_rst_q;
        rises_d     = rises_q;
        step_pend_d = step_pend_q;
        stop_req_d  = stop_req_q;
        halt_req_d  = halt_req_q;
        cnt_inc     = 1'b0;
        stop_now    = stop_req_q | ~run_s | halt_s;
        halt_now    = halt_req_q | halt_s;

        case (state_q)
            ST_RST_HOLD: begin
                // Clock the CPU while its reset is held; release reset at the
                // end of the low phase that follows the RstHold-th rising edge.
                if (tc) begin
                    if (cpu_clk_q) begin
                        cpu_clk_d = 1'b0;
                    end else if (rises_q == RhWidth'(RstHold)) begin
                        state_d   = ST_IDLE;
                        cpu_rst_d = 1'b1;
                    end else begin
                        cpu_clk_d = 1'b1;
                        rises_d   = rises_q + RhWidth'(1);
                    end
                end
            end

            ST_IDLE: begin
                // Run beats a pending step; a step seen between boundaries is
                // held (at most one) until the next tc.
                if (tc && run_s) begin
                    state_d     = ST_RUN;
                    cpu_clk_d   = 1'b1;
                    cnt_inc     = 1'b1;
                    step_pend_d = 1'b0;
                end else if (tc && (step_pend_q || step_pulse)) begin
                    state_d     = ST_STEP_HI;
                    cpu_clk_d   = 1'b1;
                    cnt_inc     = 1'b1;
                    step_pend_d = 1'b0;
                end else if (step_pulse) begin
                    step_pend_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (cpu_clk_q) begin
                    // A stop request seen anywhere in the high phase is
                    // remembered so the phase still runs to full length.
                    if (tc) begin
                        cpu_clk_d  = 1'b0;
                        stop_req_d = 1'b0;
                        halt_req_d = 1'b0;
                        if (stop_now) begin
                            state_d = halt_now ? ST_HALTED : ST_IDLE;
                        end
                    end else begin
                        stop_req_d = stop_now;
                        halt_req_d = halt_now;
                    end
                end else if (tc) begin
                    cpu_clk_d = 1'b1;
                    cnt_inc   = 1'b1;
                end
            end

            ST_STEP_HI: begin
                if (tc) begin
                    cpu_clk_d = 1'b0;
                    state_d   = ST_STEP_LO;
                end
            end

            ST_STEP_LO: begin
                if (tc) begin
                    state_d = halt_s ? ST_HALTED : ST_IDLE;
                end
            end

            ST_HALTED: begin
                // Cpu_Clk is already low here, so restarting the hold sequence
                // cannot shorten a phase.
                if (restart_pulse) begin
                    state_d   = ST_RST_HOLD;
                    cpu_rst_d = 1'b0;
                    rises_d   = '0;
                end
            end

            default: begin
                state_d   = ST_RST_HOLD;
                cpu_clk_d = 1'b0;
                cpu_rst_d = 1'b0;
                rises_d   = '0;
            end
        endcase
    end

    // Cycle counter saturates at all-ones.
    assign cnt_d = (cnt_inc && (cnt_q != '1)) ? cnt_q + CntWidth'(1) : cnt_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_RST_HOLD;
            cpu_clk_q   <= 1'b0;
            cpu_rst_q   <= 1'b0;
            rises_q     <= '0;
            step_pend_q <= 1'b0;
            stop_req_q  <= 1'b0;
            halt_req_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cpu_clk_q   <= cpu_clk_d;
            cpu_rst_q   <= cpu_rst_d;
            rises_q     <= rises_d;
            step_pend_q <= step_pend_d;
            stop_req_q  <= stop_req_d;
            halt_req_q  <= halt_req_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers).
    // ------------------------------------------------------------------
    assign bus.Cpu_Clk     = cpu_clk_q;
    assign bus.Cpu_Reset   = cpu_rst_q;
    assign bus.State       = state_q;
    assign bus.Cycle_Count = cnt_q;
    assign bus.Heartbeat   = hb_q;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// tb_cpu_clock_sequencer: directed vector table, hand sequences and randomized run against a reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_cpu_clock_sequencer;

    localparam int DIV  = 3;
    localparam int DB   = 2;
    localparam int RH   = 4;
    localparam int CW   = 4;
    localparam int PH   = DIV + 1;
    localparam int MAXC = 4096;

    // Spec state encodings.
    localparam int S_HOLD = 0;
    localparam int S_IDLE = 1;
    localparam int S_RUN  = 2;
    localparam int S_STHI = 3;
    localparam int S_STLO = 4;
    localparam int S_HALT = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    cpu_clock_sequencer_if #(.CntWidth(CW)) bus ();

    cpu_clock_sequencer #(
        .DivWidth (4),
        .DivMax   (DIV),
        .DbWidth  (4),
        .DbMax    (DB),
        .RstHold  (RH),
        .CntWidth (CW)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int st, input bit rstn, input bit cclk, input int cnt);
        check({tag, " State"},       32'(bus.State),       32'(st));
        check({tag, " Cpu_Reset"},   32'(bus.Cpu_Reset),   32'(rstn));
        check({tag, " Cpu_Clk"},     32'(bus.Cpu_Clk),     32'(cclk));
        check({tag, " Cycle_Count"}, 32'(bus.Cycle_Count), 32'(cnt));
    endtask

    task automatic drive(input bit run, input bit step, input bit rs, input bit halt);
        bus.Run_Sw   = run;
        bus.Step_Btn = step;
        bus.Restart  = rs;
        bus.Halt     = halt;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model: works per Clk edge from the rules of the block.
    // Synchronised value of an input at edge k is the raw value at edge k-2;
    // a debounced level flips when the last DB+1 synchronised samples all
    // disagree with it.
    // ------------------------------------------------------------------
    bit h_run [MAXC];
    bit h_step[MAXC];
    bit h_rs  [MAXC];
    bit h_halt[MAXC];

    bit m_en = 1'b0;
    int m_n, m_st, m_rises, m_cnt;
    bit m_clk, m_rstn, m_hb, m_pend, m_stop, m_hseen;
    bit m_lstep, m_lrs, m_pstep, m_prs;

    function automatic bit synced(input int ch, input int k);
        if (k < 2 || k - 2 >= MAXC) return 1'b0;
        case (ch)
            0:       return h_run[k-2];
            1:       return h_step[k-2];
            2:       return h_rs[k-2];
            default: return h_halt[k-2];
        endcase
    endfunction

    function automatic bit db_flip(input int ch, input int k, input bit lvl);
        if (k < DB) return 1'b0;
        for (int j = k - DB; j <= k; j++) begin
            if (synced(ch, j) == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_n = 0; m_st = S_HOLD; m_rises = 0; m_cnt = 0;
        m_clk = 0; m_rstn = 0; m_hb = 0; m_pend = 0; m_stop = 0; m_hseen = 0;
        m_lstep = 0; m_lrs = 0; m_pstep = 0; m_prs = 0;
    endtask

    task automatic bump();
        if (m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic model_step();
        bit tc, run_s, halt_s, pul_s, pul_r;
        if (m_n < MAXC) begin
            h_run[m_n]  = bus.Run_Sw;
            h_step[m_n] = bus.Step_Btn;
            h_rs[m_n]   = bus.Restart;
            h_halt[m_n] = bus.Halt;
        end
        tc     = (m_n % PH) == DIV;
        run_s  = synced(0, m_n);
        halt_s = synced(3, m_n);
        pul_s  = m_pstep;
        pul_r  = m_prs;
        m_pstep = 1'b0;
        if (db_flip(1, m_n, m_lstep)) begin m_lstep = ~m_lstep; m_pstep = m_lstep; end
        m_prs = 1'b0;
        if (db_flip(2, m_n, m_lrs)) begin m_lrs = ~m_lrs; m_prs = m_lrs; end
        if (tc) m_hb = ~m_hb;
        case (m_st)
            S_HOLD: if (tc) begin
                if (m_clk) m_clk = 1'b0;
                else if (m_rises == RH) begin m_st = S_IDLE; m_rstn = 1'b1; end
                else begin m_clk = 1'b1; m_rises++; end
            end
            S_IDLE: begin
                if (tc && run_s) begin m_st = S_RUN; m_clk = 1'b1; bump(); m_pend = 1'b0; end
                else if (tc && (m_pend || pul_s)) begin m_st = S_STHI; m_clk = 1'b1; bump(); m_pend = 1'b0; end
                else if (pul_s) m_pend = 1'b1;
            end
            S_RUN: begin
                if (m_clk) begin
                    if (!run_s || halt_s) m_stop = 1'b1;
                    if (halt_s) m_hseen = 1'b1;
                    if (tc) begin
                        m_clk = 1'b0;
                        if (m_stop) m_st = m_hseen ? S_HALT : S_IDLE;
                        m_stop = 1'b0; m_hseen = 1'b0;
                    end
                end else if (tc) begin
                    m_clk = 1'b1; bump();
                end
            end
            S_STHI: if (tc) begin m_clk = 1'b0; m_st = S_STLO; end
            S_STLO: if (tc) m_st = halt_s ? S_HALT : S_IDLE;
            default: if (pul_r) begin m_st = S_HOLD; m_rstn = 1'b0; m_rises = 0; end
        endcase
        m_n++;
    endtask

    always @(posedge clk) begin
        if (m_en) model_step();
    end

    task automatic cmp_model();
        n_checks++;
        if (bus.State !== 3'(m_st) || bus.Cpu_Clk !== m_clk || bus.Cpu_Reset !== m_rstn ||
            bus.Cycle_Count !== CW'(m_cnt) || bus.Heartbeat !== m_hb) begin
            n_errors++;
            if (n_errors <= 20)
                $display("FAIL model edge %0d: got st=%0d clk=%0b rst=%0b cnt=%0d hb=%0b, expected st=%0d clk=%0b rst=%0b cnt=%0d hb=%0b",
                         m_n, bus.State, bus.Cpu_Clk, bus.Cpu_Reset, bus.Cycle_Count, bus.Heartbeat,
                         m_st, m_clk, m_rstn, m_cnt, m_hb);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs held for 'waits' Clk, then outputs checked.
    // ------------------------------------------------------------------
    typedef struct {
        bit run;
        bit step;
        bit rs;
        bit halt;
        int waits;
        int st;
        bit rstn;
        bit cclk;
        int cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // reset release, hold sequence, IDLE
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,   4, S_HOLD, 1'b0, 1'b1,  0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0,  31, S_HOLD, 1'b0, 1'b0,  0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0,   1, S_IDLE, 1'b1, 1'b0,  0};
        // bouncy step 1,0,1,0 then held -> a single step
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0,   1, S_IDLE, 1'b1, 1'b0,  0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0,   1, S_IDLE, 1'b1, 1'b0,  0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0,   1, S_IDLE, 1'b1, 1'b0,  0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0,   1, S_IDLE, 1'b1, 1'b0,  0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0,   7, S_IDLE, 1'b1, 1'b0,  0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0,   1, S_STHI, 1'b1, 1'b1,  1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0,   4, S_STLO, 1'b1, 1'b0,  1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0,   4, S_IDLE, 1'b1, 1'b0,  1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0,   8, S_IDLE, 1'b1, 1'b0,  1};
        // free run to saturation, then stop mid-high
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0,   4, S_RUN,  1'b1, 1'b1,  2};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0,   4, S_RUN,  1'b1, 1'b0,  2};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 116, S_RUN,  1'b1, 1'b1, 15};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0,   4, S_IDLE, 1'b1, 1'b0, 15};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0,   8, S_IDLE, 1'b1, 1'b0, 15};
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("reset State",       32'(bus.State),       32'(S_HOLD));
        check("reset Cpu_Clk",     32'(bus.Cpu_Clk),     32'd0);
        check("reset Cpu_Reset",   32'(bus.Cpu_Reset),   32'd0);
        check("reset Cycle_Count", 32'(bus.Cycle_Count), 32'd0);
        check("reset Heartbeat",   32'(bus.Heartbeat),   32'd0);
        wait_cyc(3);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].run, tbl[i].step, tbl[i].rs, tbl[i].halt);
            wait_cyc(tbl[i].waits);
            check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].rstn, tbl[i].cclk, tbl[i].cnt);
        end

        // Halt raised in a low phase: next high phase completes, then HALTED.
        drive(1'b1, 1'b0, 1'b0, 1'b0); wait_cyc(8);
        check_outs("halt run", S_RUN, 1'b1, 1'b0, 15);
        drive(1'b1, 1'b0, 1'b0, 1'b1); wait_cyc(4);
        check_outs("halt high", S_RUN, 1'b1, 1'b1, 15);
        wait_cyc(4);
        check_outs("halt stop", S_HALT, 1'b1, 1'b0, 15);
        drive(1'b1, 1'b1, 1'b0, 1'b1); wait_cyc(6);
        drive(1'b1, 1'b0, 1'b0, 1'b1); wait_cyc(10);
        check_outs("halt ignores", S_HALT, 1'b1, 1'b0, 15);
        drive(1'b0, 1'b0, 1'b1, 1'b0); wait_cyc(5);
        check_outs("restart wait", S_HALT, 1'b1, 1'b0, 15);
        wait_cyc(1);
        check_outs("restart", S_HOLD, 1'b0, 1'b0, 15);
        drive(1'b0, 1'b0, 1'b0, 1'b0); wait_cyc(33);
        check_outs("rehold", S_HOLD, 1'b0, 1'b0, 15);
        wait_cyc(1);
        check_outs("rehold done", S_IDLE, 1'b1, 1'b0, 15);

        // Run and a pending step in the same IDLE phase: run wins, step dropped.
        drive(1'b0, 1'b1, 1'b0, 1'b0); wait_cyc(4);
        check_outs("simul pend", S_IDLE, 1'b1, 1'b0, 15);
        drive(1'b1, 1'b1, 1'b0, 1'b0); wait_cyc(4);
        check_outs("simul run", S_RUN, 1'b1, 1'b1, 15);
        drive(1'b0, 1'b0, 1'b0, 1'b0); wait_cyc(4);
        check_outs("simul stop", S_IDLE, 1'b1, 1'b0, 15);
        wait_cyc(12);
        check_outs("simul nostep", S_IDLE, 1'b1, 1'b0, 15);

        // Asynchronous reset in the middle of STEP_HI.
        drive(1'b0, 1'b1, 1'b0, 1'b0); wait_cyc(8);
        check_outs("pre areset", S_STHI, 1'b1, 1'b1, 15);
        #2 rst_n = 1'b0;
        #1;
        check_outs("areset", S_HOLD, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized rounds against the reference model.
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            rst_n = 1'b0;
            m_en  = 1'b0;
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            wait_cyc(3);
            model_reset();
            rst_n = 1'b1;
            m_en  = 1'b1;
            begin
                int cyc;
                bit run;
                cyc = 0;
                run = 1'b0;
                while (cyc < 1000) begin
                    int dur;
                    if ($urandom_range(0, 3) == 0) run = ~run;
                    drive(run,
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 9) == 0));
                    dur = $urandom_range(1, 24);
                    for (int i = 0; i < dur; i++) begin
                        @(negedge clk);
                        cmp_model();
                        cyc++;
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
